// File: rtl/vga_sync_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, H/V counters, programmable-polarity
// syncs, coordinate request, frame-start strobe and a registered colour stage aligned to sync.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned COLOR_W  = 4,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3*COLOR_W-1:0]   rgb_in,
    output logic [CNT_W-1:0]       pix_x,
    output logic [CNT_W-1:0]       pix_y,
    output logic                   video_on,
    output logic                   pix_tick,
    output logic                   frame_start,
    output logic                   VGA_Hsync_n,
    output logic                   VGA_Vsync_n,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RGB_W    = 3 * COLOR_W;
    localparam logic        SYNC_IDLE = ~SYNC_POL;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             von_q, von_d;
    logic             fs_q, fs_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic             h_wrap;
    logic             v_wrap;
    logic             hs0;
    logic             vs0;

    // Divider: tick_q is a registered copy of (div_q == CLK_DIV-1); stays high when CLK_DIV=1.
    always_comb begin
        div_d  = div_q;
        tick_d = tick_q;
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        tick_d = (div_d == DIV_W'(CLK_DIV - 1));
    end

    // Stage-0 timing counters and the decodes that depend on the next coordinates.
    always_comb begin
        h_wrap = (h_q == CNT_W'(H_TOTAL - 1));
        v_wrap = (v_q == CNT_W'(V_TOTAL - 1));
        h_d    = h_q;
        v_d    = v_q;
        fs_d   = 1'b0;
        if (tick_q) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
            fs_d = h_wrap && v_wrap;
        end
        von_d = (h_d < CNT_W'(H_ACTIVE)) && (v_d < CNT_W'(V_ACTIVE));
    end

    always_comb begin
        hs0 = (h_q >= CNT_W'(HS_START)) && (h_q < CNT_W'(HS_END));
        vs0 = (v_q >= CNT_W'(VS_START)) && (v_q < CNT_W'(VS_END));
    end

    // Stage 1: pins capture the current coordinate's sync/colour on each tick and hold between.
    always_comb begin
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        if (tick_q) begin
            hs_d  = hs0 ^ SYNC_IDLE;
            vs_d  = vs0 ^ SYNC_IDLE;
            rgb_d = von_q ? rgb_in : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= (CLK_DIV == 1);
            h_q    <= '0;
            v_q    <= '0;
            von_q  <= (H_ACTIVE > 0) && (V_ACTIVE > 0);
            fs_q   <= 1'b0;
            hs_q   <= SYNC_IDLE;
            vs_q   <= SYNC_IDLE;
            rgb_q  <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
            von_q  <= von_d;
            fs_q   <= fs_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign video_on    = von_q;
    assign pix_tick    = tick_q;
    assign frame_start = fs_q;
    assign VGA_Hsync_n = hs_q;
    assign VGA_Vsync_n = vs_q;
    assign VGA_R       = rgb_q[RGB_W-1 -: COLOR_W];
    assign VGA_G       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B       = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: two small-timing instances (CLK_DIV=1 active-low syncs,
// CLK_DIV=3 active-high syncs) with per-clock expectations queued by the stimulus.
module tb_vga_sync_gen;

    typedef struct packed {
        logic        tick;
        logic [10:0] x;
        logic [10:0] y;
        logic        von;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rgb_a = 12'h000;
    logic [11:0] rgb_b = 12'h000;

    logic [10:0] a_x, a_y, b_x, b_y;
    logic        a_von, a_tick, a_fs, a_hs, a_vs;
    logic        b_von, b_tick, b_fs, b_hs, b_vs;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .COLOR_W(4), .SYNC_POL(1'b0), .CNT_W(11)
    ) dut_a (
        .clk(clk), .rst(rst), .rgb_in(rgb_a),
        .pix_x(a_x), .pix_y(a_y), .video_on(a_von), .pix_tick(a_tick),
        .frame_start(a_fs), .VGA_Hsync_n(a_hs), .VGA_Vsync_n(a_vs),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(3), .COLOR_W(4), .SYNC_POL(1'b1), .CNT_W(11)
    ) dut_b (
        .clk(clk), .rst(rst), .rgb_in(rgb_b),
        .pix_x(b_x), .pix_y(b_y), .video_on(b_von), .pix_tick(b_tick),
        .frame_start(b_fs), .VGA_Hsync_n(b_hs), .VGA_Vsync_n(b_vs),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
    );

    function automatic logic [11:0] pat(input int i);
        case (i % 8)
            0:       return 12'hF0A;
            1:       return 12'h123;
            2:       return 12'hFFF;
            3:       return 12'h5A5;
            4:       return 12'hF0A;
            5:       return 12'h0F0;
            6:       return 12'h987;
            default: return 12'h001;
        endcase
    endfunction

    // Small timing: line = 14 pixels (active 0..7, hsync 10..11), frame = 7 lines (active 0..3, vsync 5).
    function automatic exp_t exp_at(input int j, input int d, input bit pol, input int ofs);
        exp_t e;
        int n, p, m, h, v, pm, ph, pv;
        n = j / d;
        p = j % d;
        m = n % 98;
        h = m % 14;
        v = m / 14;
        e.tick = (p == d - 1);
        e.x    = 11'(h);
        e.y    = 11'(v);
        e.von  = (h < 8) && (v < 4);
        e.fs   = (p == 0) && (n > 0) && (m == 0);
        if (n == 0) begin
            e.rgb = 12'h000;
            e.hs  = ~pol;
            e.vs  = ~pol;
        end else begin
            pm    = (n - 1) % 98;
            ph    = pm % 14;
            pv    = pm / 14;
            e.rgb = ((ph < 8) && (pv < 4)) ? pat(n - 1 + ofs) : 12'h000;
            e.hs  = (ph == 10 || ph == 11) ? pol : ~pol;
            e.vs  = (pv == 5) ? pol : ~pol;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic check_one(input string tag, input exp_t e, input exp_t a);
        chk({tag, ".pix_tick"},    16'(a.tick), 16'(e.tick));
        chk({tag, ".pix_x"},       16'(a.x),    16'(e.x));
        chk({tag, ".pix_y"},       16'(a.y),    16'(e.y));
        chk({tag, ".video_on"},    16'(a.von),  16'(e.von));
        chk({tag, ".frame_start"}, 16'(a.fs),   16'(e.fs));
        chk({tag, ".hsync"},       16'(a.hs),   16'(e.hs));
        chk({tag, ".vsync"},       16'(a.vs),   16'(e.vs));
        chk({tag, ".rgb"},         16'(a.rgb),  16'(e.rgb));
    endtask

    // Monitor: one expectation per DUT per clock, compared on the falling edge.
    always @(negedge clk) begin
        exp_t ea, eb, aa, ab;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            aa = '{tick: a_tick, x: a_x, y: a_y, von: a_von, fs: a_fs,
                   hs: a_hs, vs: a_vs, rgb: {a_r, a_g, a_b}};
            check_one("div1", ea, aa);
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            ab = '{tick: b_tick, x: b_x, y: b_y, von: b_von, fs: b_fs,
                   hs: b_hs, vs: b_vs, rgb: {b_r, b_g, b_b}};
            check_one("div3", eb, ab);
        end
    end

    task automatic push_reset();
        q_a.push_back(exp_at(0, 1, 1'b0, 0));
        q_b.push_back(exp_at(0, 3, 1'b1, 3));
    endtask

    task automatic drive(input int j);
        rgb_a = pat(j);
        rgb_b = pat(j / 3 + 3);
    endtask

    // Release reset on the first edge, then run ncyc clocks of normal timing.
    task automatic run(input int ncyc);
        for (int j = 0; j < ncyc; j++) begin
            @(posedge clk);
            #1;
            if (j == 0) rst = 1'b0;
            drive(j);
            q_a.push_back(exp_at(j, 1, 1'b0, 0));
            q_b.push_back(exp_at(j, 3, 1'b1, 3));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            push_reset();
        end
        run(711);
        // Cycle 711: div1 instance is mid-hsync; reset lands between edges.
        @(posedge clk);
        #1;
        drive(711);
        #1;
        rst = 1'b1;
        push_reset();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            push_reset();
        end
        run(320);
        repeat (2) @(negedge clk);
        chk("queue_drain", 16'(q_a.size() + q_b.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
